mem_port_arbiter: RTL and testbench

//  Responder side of the CPU's split memory interface: serves the inst_mem_* and data_mem_*

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the split-port memory arbiter: LC-3b word/mask types,
// arbiter FSM state, port identifiers and the latched request payload.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned MASK_W = 2;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [MASK_W-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D,
        ARB_RESPOND
    } arb_state_t;

    typedef enum logic {
        ARB_INST,
        ARB_DATA
    } arb_port_t;

    // Request payload as selected from the winning port in IDLE.
    typedef struct packed {
        logic          write;
        lc3b_mem_wmask byte_enable;
        lc3b_word      addr;
        lc3b_word      wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One memory request/response port; used for the inst, data and physical sides.
// master drives the request, slave returns resp/rdata.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic          read;
    logic          write;
    lc3b_mem_wmask byte_enable;
    lc3b_word      addr;
    lc3b_word      wdata;
    logic          resp;
    lc3b_word      rdata;

    modport master (
        output read, write, byte_enable, addr, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, byte_enable, addr, wdata,
        output resp, rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Merges the CPU inst/data memory ports onto one physical port, one transaction
// at a time, alternating grants under contention and pulsing a registered resp.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FIRST_GRANT_DATA = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  inst_mem,
    mem_port_arbiter_if.slave  data_mem,
    mem_port_arbiter_if.master pmem
);

    // Seeding last_grant with the other port makes the first contention go our way.
    localparam arb_port_t RESET_LAST_GRANT = FIRST_GRANT_DATA ? ARB_INST : ARB_DATA;

    arb_state_t state;
    arb_port_t  last_grant;

    logic       req_i_c;
    logic       req_d_c;
    arb_port_t  grant_c;
    mem_req_t   sel_req_c;

    // Grant selection and payload mux, only consumed in IDLE.
    always_comb begin
        req_i_c   = inst_mem.read | inst_mem.write;
        req_d_c   = data_mem.read | data_mem.write;
        grant_c   = ARB_INST;
        sel_req_c = '{write:       inst_mem.write,
                      byte_enable: inst_mem.byte_enable,
                      addr:        inst_mem.addr,
                      wdata:       inst_mem.wdata};

        if (req_i_c && req_d_c) begin
            grant_c = (last_grant == ARB_INST) ? ARB_DATA : ARB_INST;
        end else if (req_d_c) begin
            grant_c = ARB_DATA;
        end

        if (grant_c == ARB_DATA) begin
            sel_req_c = '{write:       data_mem.write,
                          byte_enable: data_mem.byte_enable,
                          addr:        data_mem.addr,
                          wdata:       data_mem.wdata};
        end
    end

    // The pmem_* output registers double as the request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ARB_IDLE;
            last_grant       <= RESET_LAST_GRANT;
            pmem.read        <= 1'b0;
            pmem.write       <= 1'b0;
            pmem.byte_enable <= '0;
            pmem.addr        <= '0;
            pmem.wdata       <= '0;
            inst_mem.resp    <= 1'b0;
            inst_mem.rdata   <= '0;
            data_mem.resp    <= 1'b0;
            data_mem.rdata   <= '0;
        end else begin
            inst_mem.resp <= 1'b0;
            data_mem.resp <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (req_i_c || req_d_c) begin
                        pmem.read        <= ~sel_req_c.write;
                        pmem.write       <= sel_req_c.write;
                        pmem.byte_enable <= sel_req_c.byte_enable;
                        pmem.addr        <= sel_req_c.addr;
                        pmem.wdata       <= sel_req_c.wdata;
                        last_grant       <= grant_c;
                        state            <= (grant_c == ARB_DATA) ? ARB_BUSY_D : ARB_BUSY_I;
                    end
                end

                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (pmem.resp) begin
                        if (pmem.read) begin
                            if (state == ARB_BUSY_I) begin
                                inst_mem.rdata <= pmem.rdata;
                            end else begin
                                data_mem.rdata <= pmem.rdata;
                            end
                        end
                        if (state == ARB_BUSY_I) begin
                            inst_mem.resp <= 1'b1;
                        end else begin
                            data_mem.resp <= 1'b1;
                        end
                        pmem.read        <= 1'b0;
                        pmem.write       <= 1'b0;
                        pmem.byte_enable <= '0;
                        pmem.addr        <= '0;
                        pmem.wdata       <= '0;
                        state            <= ARB_RESPOND;
                    end
                end

                ARB_RESPOND: begin
                    state <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-port read/write, contention
// ordering, request latching, read&write priority, stray pmem_resp and reset abort.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if inst_if ();
    mem_port_arbiter_if data_if ();
    mem_port_arbiter_if pmem_if ();

    mem_port_arbiter #(
        .FIRST_GRANT_DATA(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst_mem (inst_if),
        .data_mem (data_if),
        .pmem     (pmem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inst_if.read = 1'b0; inst_if.write = 1'b0; inst_if.byte_enable = 2'b00;
        inst_if.addr = 16'h0; inst_if.wdata = 16'h0;
        data_if.read = 1'b0; data_if.write = 1'b0; data_if.byte_enable = 2'b00;
        data_if.addr = 16'h0; data_if.wdata = 16'h0;
        pmem_if.resp = 1'b0; pmem_if.rdata = 16'h0;
        #3;
        n_cmp++; if (pmem_if.read !== 1'b0 || pmem_if.write !== 1'b0) begin n_err++; $display("FAIL reset_pmem_op: got r=%b w=%b want 0/0", pmem_if.read, pmem_if.write); end
        n_cmp++; if (pmem_if.addr !== 16'h0 || pmem_if.wdata !== 16'h0 || pmem_if.byte_enable !== 2'b00) begin n_err++; $display("FAIL reset_pmem_bus: got a=%h d=%h be=%b want 0", pmem_if.addr, pmem_if.wdata, pmem_if.byte_enable); end
        n_cmp++; if (inst_if.resp !== 1'b0 || data_if.resp !== 1'b0) begin n_err++; $display("FAIL reset_resp: got i=%b d=%b want 0/0", inst_if.resp, data_if.resp); end
        n_cmp++; if (inst_if.rdata !== 16'h0 || data_if.rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got i=%h d=%h want 0/0", inst_if.rdata, data_if.rdata); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_inst_read();
        inst_if.read = 1'b1; inst_if.addr = 16'h1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (pmem_if.read !== 1'b1 || pmem_if.write !== 1'b0 || pmem_if.addr !== 16'h1000) begin n_err++; $display("FAIL t1_pmem_held[%0d]: got r=%b w=%b a=%h want 1/0/1000", i, pmem_if.read, pmem_if.write, pmem_if.addr); end
            n_cmp++; if (inst_if.resp !== 1'b0 || data_if.resp !== 1'b0) begin n_err++; $display("FAIL t1_early_resp[%0d]: got i=%b d=%b want 0/0", i, inst_if.resp, data_if.resp); end
            if (i == 3) begin pmem_if.resp = 1'b1; pmem_if.rdata = 16'hBEEF; end
        end
        tick();
        n_cmp++; if (inst_if.resp !== 1'b1 || inst_if.rdata !== 16'hBEEF) begin n_err++; $display("FAIL t1_resp: got resp=%b rdata=%h want 1/beef", inst_if.resp, inst_if.rdata); end
        n_cmp++; if (data_if.resp !== 1'b0 || pmem_if.read !== 1'b0) begin n_err++; $display("FAIL t1_other: got dresp=%b pread=%b want 0/0", data_if.resp, pmem_if.read); end
        pmem_if.resp = 1'b0; pmem_if.rdata = 16'h0; inst_if.read = 1'b0;
        tick();
        n_cmp++; if (inst_if.resp !== 1'b0 || inst_if.rdata !== 16'hBEEF) begin n_err++; $display("FAIL t1_single_pulse: got resp=%b rdata=%h want 0/beef", inst_if.resp, inst_if.rdata); end
    endtask

    task automatic test_data_write();
        data_if.write = 1'b1; data_if.addr = 16'h2002; data_if.wdata = 16'h00A5; data_if.byte_enable = 2'b01;
        tick();
        n_cmp++; if (pmem_if.write !== 1'b1 || pmem_if.read !== 1'b0) begin n_err++; $display("FAIL t2_op: got r=%b w=%b want 0/1", pmem_if.read, pmem_if.write); end
        n_cmp++; if (pmem_if.addr !== 16'h2002 || pmem_if.wdata !== 16'h00A5 || pmem_if.byte_enable !== 2'b01) begin n_err++; $display("FAIL t2_bus: got a=%h d=%h be=%b want 2002/00a5/01", pmem_if.addr, pmem_if.wdata, pmem_if.byte_enable); end
        pmem_if.resp = 1'b1; pmem_if.rdata = 16'hDEAD;
        tick();
        n_cmp++; if (data_if.resp !== 1'b1 || data_if.rdata !== 16'h0000) begin n_err++; $display("FAIL t2_resp: got resp=%b rdata=%h want 1/0000", data_if.resp, data_if.rdata); end
        n_cmp++; if (inst_if.resp !== 1'b0 || inst_if.rdata !== 16'hBEEF || pmem_if.write !== 1'b0) begin n_err++; $display("FAIL t2_other: got iresp=%b irdata=%h pwrite=%b want 0/beef/0", inst_if.resp, inst_if.rdata, pmem_if.write); end
        pmem_if.resp = 1'b0; data_if.write = 1'b0;
        tick();
        n_cmp++; if (data_if.resp !== 1'b0) begin n_err++; $display("FAIL t2_single_pulse: got %b want 0", data_if.resp); end
    endtask

    task automatic test_contention();
        bit       exp_data;
        logic [15:0] exp_addr;
        rst_n = 1'b0;
        inst_if.read = 1'b1; inst_if.addr = 16'h0100;
        data_if.read = 1'b1; data_if.addr = 16'h0200;
        pmem_if.resp = 1'b1; pmem_if.rdata = 16'hA000;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            pmem_if.rdata = 16'(32'hA000 + c);
            exp_data = (((c - 1) / 3) % 2) == 0;
            exp_addr = exp_data ? 16'h0200 : 16'h0100;
            if (c % 3 == 1) begin
                n_cmp++; if (pmem_if.read !== 1'b1 || pmem_if.addr !== exp_addr) begin n_err++; $display("FAIL t3_grant c%0d: got r=%b a=%h want 1/%h", c, pmem_if.read, pmem_if.addr, exp_addr); end
            end else if (c % 3 == 2) begin
                if (exp_data) begin
                    n_cmp++; if (data_if.resp !== 1'b1 || inst_if.resp !== 1'b0 || data_if.rdata !== 16'(32'hA000 + c - 1)) begin n_err++; $display("FAIL t3_dresp c%0d: got d=%b i=%b rd=%h want 1/0/%h", c, data_if.resp, inst_if.resp, data_if.rdata, 16'(32'hA000 + c - 1)); end
                end else begin
                    n_cmp++; if (inst_if.resp !== 1'b1 || data_if.resp !== 1'b0 || inst_if.rdata !== 16'(32'hA000 + c - 1)) begin n_err++; $display("FAIL t3_iresp c%0d: got i=%b d=%b rd=%h want 1/0/%h", c, inst_if.resp, data_if.resp, inst_if.rdata, 16'(32'hA000 + c - 1)); end
                end
            end else begin
                n_cmp++; if (inst_if.resp !== 1'b0 || data_if.resp !== 1'b0 || pmem_if.read !== 1'b0) begin n_err++; $display("FAIL t3_idle c%0d: got i=%b d=%b pr=%b want 0/0/0", c, inst_if.resp, data_if.resp, pmem_if.read); end
            end
        end
        inst_if.read = 1'b0; data_if.read = 1'b0; pmem_if.resp = 1'b0;
        tick();
        n_cmp++; if (pmem_if.read !== 1'b0) begin n_err++; $display("FAIL t3_drain: got pread=%b want 0", pmem_if.read); end
    endtask

    task automatic test_addr_latch();
        data_if.read = 1'b1; data_if.addr = 16'h3000;
        tick();
        n_cmp++; if (pmem_if.read !== 1'b1 || pmem_if.addr !== 16'h3000) begin n_err++; $display("FAIL t4_start: got r=%b a=%h want 1/3000", pmem_if.read, pmem_if.addr); end
        data_if.addr = 16'h4000;
        tick();
        n_cmp++; if (pmem_if.addr !== 16'h3000) begin n_err++; $display("FAIL t4_hold1: got %h want 3000", pmem_if.addr); end
        tick();
        n_cmp++; if (pmem_if.addr !== 16'h3000) begin n_err++; $display("FAIL t4_hold2: got %h want 3000", pmem_if.addr); end
        pmem_if.resp = 1'b1; pmem_if.rdata = 16'h1234;
        tick();
        n_cmp++; if (data_if.resp !== 1'b1 || data_if.rdata !== 16'h1234) begin n_err++; $display("FAIL t4_resp: got resp=%b rdata=%h want 1/1234", data_if.resp, data_if.rdata); end
        pmem_if.resp = 1'b0; data_if.read = 1'b0;
        tick();
    endtask

    task automatic test_read_write_both();
        data_if.read = 1'b1; data_if.write = 1'b1; data_if.addr = 16'h6000;
        data_if.wdata = 16'h0F0F; data_if.byte_enable = 2'b11;
        tick();
        n_cmp++; if (pmem_if.read !== 1'b0 || pmem_if.write !== 1'b1) begin n_err++; $display("FAIL t6_op: got r=%b w=%b want 0/1", pmem_if.read, pmem_if.write); end
        n_cmp++; if (pmem_if.wdata !== 16'h0F0F || pmem_if.byte_enable !== 2'b11 || pmem_if.addr !== 16'h6000) begin n_err++; $display("FAIL t6_bus: got a=%h d=%h be=%b want 6000/0f0f/11", pmem_if.addr, pmem_if.wdata, pmem_if.byte_enable); end
        pmem_if.resp = 1'b1; pmem_if.rdata = 16'hFFFF;
        tick();
        n_cmp++; if (data_if.resp !== 1'b1 || data_if.rdata !== 16'h1234) begin n_err++; $display("FAIL t6_resp: got resp=%b rdata=%h want 1/1234", data_if.resp, data_if.rdata); end
        pmem_if.resp = 1'b0; data_if.read = 1'b0; data_if.write = 1'b0;
        tick();
    endtask

    task automatic test_stray_resp();
        pmem_if.resp = 1'b1; pmem_if.rdata = 16'h7777;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (inst_if.resp !== 1'b0 || data_if.resp !== 1'b0 || pmem_if.read !== 1'b0) begin n_err++; $display("FAIL t7_stray_resp[%0d]: got i=%b d=%b pr=%b want 0/0/0", i, inst_if.resp, data_if.resp, pmem_if.read); end
            n_cmp++; if (inst_if.rdata !== 16'hA00A || data_if.rdata !== 16'h1234) begin n_err++; $display("FAIL t7_stray_rdata[%0d]: got i=%h d=%h want a00a/1234", i, inst_if.rdata, data_if.rdata); end
        end
        pmem_if.resp = 1'b0;
    endtask

    task automatic test_reset_abort();
        inst_if.read = 1'b1; inst_if.addr = 16'h0500;
        tick();
        n_cmp++; if (pmem_if.read !== 1'b1 || pmem_if.addr !== 16'h0500) begin n_err++; $display("FAIL t5_busy: got r=%b a=%h want 1/0500", pmem_if.read, pmem_if.addr); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pmem_if.read !== 1'b0 || pmem_if.addr !== 16'h0000) begin n_err++; $display("FAIL t5_async_drop: got r=%b a=%h want 0/0000", pmem_if.read, pmem_if.addr); end
        inst_if.addr = 16'h0000;
        tick();
        n_cmp++; if (inst_if.resp !== 1'b0 || pmem_if.read !== 1'b0) begin n_err++; $display("FAIL t5_no_resp: got iresp=%b pr=%b want 0/0", inst_if.resp, pmem_if.read); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (pmem_if.read !== 1'b1 || pmem_if.addr !== 16'h0000) begin n_err++; $display("FAIL t5_restart: got r=%b a=%h want 1/0000", pmem_if.read, pmem_if.addr); end
        pmem_if.resp = 1'b1; pmem_if.rdata = 16'h5A5A;
        tick();
        n_cmp++; if (inst_if.resp !== 1'b1 || inst_if.rdata !== 16'h5A5A) begin n_err++; $display("FAIL t5_resp: got resp=%b rdata=%h want 1/5a5a", inst_if.resp, inst_if.rdata); end
        pmem_if.resp = 1'b0; inst_if.read = 1'b0;
        tick();
        n_cmp++; if (inst_if.resp !== 1'b0) begin n_err++; $display("FAIL t5_single_pulse: got %b want 0", inst_if.resp); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_inst_read();
        test_data_write();
        test_contention();
        test_addr_latch();
        test_read_write_both();
        test_stray_resp();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
